// File: rtl/dsc_pkg.sv
// Shared types and sizing helpers for the stochastic serial multiplier.
package dsc_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } dsc_state_e;

  // Run-length width for the default configuration (5-bit operands, two inputs).
  localparam int unsigned RUN_LEN_W = 5 * 2 + 1;

  // Bits needed to count a full run of 2^(data_width*num_inputs) cycles.
  function automatic int unsigned run_len_width(input int unsigned data_width,
                                                input int unsigned num_inputs);
    return data_width * num_inputs + 1;
  endfunction

endpackage

// File: rtl/dsc_unary_sng.sv
// Unary stream generator: one counter stage plus its comparator.
// Optional DSC_EARLY_TERM_EN adds a next-count match output.
module dsc_unary_sng #(
  parameter int unsigned DATA_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] operand,
`ifdef DSC_EARLY_TERM_EN
  input  logic [DATA_WIDTH-1:0] target,
  output logic                  hit_next,
`endif
  output logic                  stream,
  output logic                  wrap
);

  logic [DATA_WIDTH-1:0] count_q;

  // Counter advances on enable, cleared outside a run.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign stream = (count_q < operand);
  assign wrap   = en && (count_q == {DATA_WIDTH{1'b1}});

`ifdef DSC_EARLY_TERM_EN
  // Value this stage will hold after the current edge equals the target.
  assign hit_next = ((en ? count_q + 1'b1 : count_q) == target);
`endif

endmodule

// File: rtl/dsc_serial_mul_seq.sv
// Sequential stochastic multiplier: product = count of cycles where all unary
// streams are high over the full counter space.
// Optional DSC_EARLY_TERM_EN stops once the top stream can no longer be high.
module dsc_serial_mul_seq
  import dsc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned OUT_WIDTH  = DATA_WIDTH * NUM_INPUTS + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             abort,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] bin_data_in,
  output logic                             busy,
  output logic                             done,
  output logic [OUT_WIDTH-1:0]             bin_data_out
);

  localparam int unsigned AccW = run_len_width(DATA_WIDTH, NUM_INPUTS);

  dsc_state_e            state_q;
  logic [DATA_WIDTH-1:0] op_q [NUM_INPUTS];
  logic [AccW-1:0]       acc_q;
  logic [AccW-1:0]       acc_next;
  logic [NUM_INPUTS-1:0] en;
  logic [NUM_INPUTS-1:0] wrap;
  logic [NUM_INPUTS-1:0] stream;
  logic                  run;
  logic                  run_end;

  assign run = (state_q == StRun);

`ifdef DSC_EARLY_TERM_EN
  logic [NUM_INPUTS-1:0] hit;
  logic                  any_zero;

  // A zero operand makes the product zero, so one run cycle is enough.
  always_comb begin
    any_zero = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (op_q[i] == '0) any_zero = 1'b1;
    end
  end
`endif

  // Counter chain: stage 0 ticks every run cycle, stage i on wrap of stage i-1.
  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_stage
    if (g == 0) begin : g_first
      assign en[g] = run;
    end else begin : g_next
      assign en[g] = wrap[g-1];
    end

    dsc_unary_sng #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_sng (
      .clk     (clk),
      .rst     (rst),
      .clr     (!run),
      .en      (en[g]),
      .operand (op_q[g]),
`ifdef DSC_EARLY_TERM_EN
      // Stop point: top counter reaches its operand with all lower stages at 0.
      .target  ((g == NUM_INPUTS - 1) ? op_q[g] : '0),
      .hit_next(hit[g]),
`endif
      .stream  (stream[g]),
      .wrap    (wrap[g])
    );
  end

  assign acc_next = acc_q + AccW'(&stream);

`ifdef DSC_EARLY_TERM_EN
  assign run_end = wrap[NUM_INPUTS-1] || any_zero || (&hit);
`else
  assign run_end = wrap[NUM_INPUTS-1];
`endif

  // Controller with registered status outputs and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      op_q         <= '{default: '0};
      acc_q        <= '0;
      bin_data_out <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
              op_q[i] <= bin_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
            acc_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (abort) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else begin
            acc_q <= acc_next;
            if (run_end) begin
              bin_data_out <= OUT_WIDTH'(acc_next);
              done         <= 1'b1;
              state_q      <= StDone;
            end
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/dsc_serial_mul_seq.md
DSC_SERIAL_MUL_SEQ -- requirements
Module: dsc_serial_mul_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 5: bits per operand.
REQ-002 SHALL have parameter NUM_INPUTS, default 2: operand count, legal range 2..4.
REQ-003 SHALL have parameter OUT_WIDTH, default DATA_WIDTH*NUM_INPUTS+1: result width, minimum DATA_WIDTH*NUM_INPUTS.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: request a new multiply.
REQ-007 SHALL have port abort, input, 1 bit: cancel the run in progress.
REQ-008 SHALL have port bin_data_in, input, NUM_INPUTS*DATA_WIDTH bits: operands, unsigned; operand i is bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port busy, output, 1 bit: high in RUN and DONE.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port bin_data_out, output, OUT_WIDTH bits: last completed product.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE; DONE lasts exactly one cycle, then IDLE.
REQ-013 In IDLE, start=1 SHALL latch all operands into internal registers and move to RUN the next cycle; later bin_data_in changes have no effect.
REQ-014 SHALL keep one DATA_WIDTH counter per input on clk only (no derived clocks): ctr[0] +1 every RUN cycle; ctr[i] +1 when ctr[i-1] wraps from 2^DATA_WIDTH-1 to 0.
REQ-015 Stream bit i SHALL be (ctr[i] < operand[i]); product bit = AND of all stream bits; accumulator +1 on each RUN cycle with product bit 1.
REQ-016 Full run SHALL be 2^(DATA_WIDTH*NUM_INPUTS) RUN cycles, ending when all counters wrap together; the accumulator then equals the exact integer product.
REQ-017 On leaving RUN normally: bin_data_out <= accumulator, done=1 for that DONE cycle; bin_data_out holds until the next completion.
REQ-018 start in RUN or DONE SHALL be ignored (no queueing).
REQ-019 abort=1 in RUN SHALL go to IDLE next cycle; no done, bin_data_out unchanged; abort in IDLE/DONE is ignored.
REQ-020 Counters and accumulator SHALL clear on entry to RUN; accumulator does not saturate (OUT_WIDTH >= product width).

Reset
REQ-021 rst=1 SHALL force IDLE, clear counters, accumulator and operand latches, and set bin_data_out=0, done=0, busy=0 on the next edge.
REQ-022 rst SHALL override start and abort; reset mid-run discards the run with no done pulse.

Configuration
REQ-023 Macro DSC_EARLY_TERM_EN defined: RUN SHALL end when ctr[NUM_INPUTS-1]==operand[NUM_INPUTS-1] with all lower counters 0, giving operand[NUM_INPUTS-1]*2^(DATA_WIDTH*(NUM_INPUTS-1)) RUN cycles; a zero operand SHALL give one RUN cycle, then DONE with result 0.
REQ-024 Macro DSC_EARLY_TERM_EN absent: every run SHALL take the full length of REQ-016, whatever the operands.

Structure
REQ-025 Package dsc_pkg SHALL hold the FSM state enum typedef and a localparam for run-length width (DATA_WIDTH*NUM_INPUTS+1).
REQ-026 One sub-module dsc_unary_sng SHALL hold the counter, comparator, enable-in and wrap-out; it SHALL be instantiated NUM_INPUTS times in a generate loop.

Verification (DATA_WIDTH=5, NUM_INPUTS=2; start seen at cycle 0)
REQ-027 Operands 31, 31: done at cycle 1025, bin_data_out=961; busy high from cycle 1 through cycle 1025.
REQ-028 Operands 17 and 5: bin_data_out=85. Then 0 and 22: bin_data_out=0, done at cycle 1025 (early-term off) or cycle 2 (early-term on).
REQ-029 Early-term on, operand0=3, operand1=4: 128 RUN cycles, done at cycle 129, result 12.
REQ-030 abort at cycle 500 of a 9*9 run: IDLE at 501, no done, bin_data_out keeps its previous value; start at cycle 600 is then accepted.
REQ-031 start pulses during RUN, and rst at cycle 300, SHALL be ignored and honoured respectively: after rst, all outputs 0, IDLE, no done.
